wb_mux_arb: RTL



---
 rtl/wb_mux_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/wb_mux_arb.sv
// wb_mux_arb: Wishbone multi-master to single-slave mux with grant FSM, watchdog and bus hold
module wb_mux_arb #(
  parameter int MASTERS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH*MASTERS-1:0]  m_adr_i,
  input  logic [DATA_WIDTH*MASTERS-1:0]  m_dat_i,
  input  logic [MASTERS-1:0]             m_cyc_i,
  input  logic [MASTERS-1:0]             m_stb_i,
  input  logic [MASTERS-1:0]             m_we_i,
  input  logic [DATA_WIDTH/8*MASTERS-1:0] m_sel_i,
  input  logic [3*MASTERS-1:0]           m_cti_i,
  input  logic [2*MASTERS-1:0]           m_bte_i,
  output logic [DATA_WIDTH*MASTERS-1:0]  m_dat_o,
  output logic [MASTERS-1:0]             m_ack_o,
  output logic [MASTERS-1:0]             m_err_o,
  output logic [MASTERS-1:0]             m_rty_o,
  output logic [ADDR_WIDTH-1:0]          s_adr_o,
  output logic [DATA_WIDTH-1:0]          s_dat_o,
  output logic [DATA_WIDTH/8-1:0]        s_sel_o,
  output logic                           s_we_o,
  output logic [2:0]                     s_cti_o,
  output logic [1:0]                     s_bte_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  input  logic                           bus_hold,
  output logic                           bus_hold_ack,
  output logic [MASTERS-1:0]             grant_o,
  output logic                           timeout_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW        = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, ABORT, HOLD} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          g_q, g_d, ptr_q, ptr_d, win;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   tmo_q, tmo_d, own, resp, waiting, fire;
  assign own     = (state_q == GRANT) || (state_q == ABORT);
  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign waiting = (state_q == GRANT) && m_cyc_i[g_q] && m_stb_i[g_q] && !resp;
  assign fire    = (TIMEOUT > 0) && waiting && (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
  // Loops run from the far end so the last hit is the winner: nearest to ptr+1 or lowest index.
  always_comb begin
    win = '0;
    if (ARB_MODE != 0) begin
      for (int i = MASTERS - 1; i >= 0; i--)
        if (m_cyc_i[i]) win = IW'(i);
    end else begin
      for (int i = MASTERS; i >= 1; i--)
        if (m_cyc_i[(int'(ptr_q) + i) % MASTERS]) win = IW'((int'(ptr_q) + i) % MASTERS);
    end
  end
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    tmo_d   = fire;
    cnt_d   = ((TIMEOUT > 0) && waiting && !fire) ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: begin
        if (bus_hold) state_d = HOLD;
        else if (|m_cyc_i) begin
          state_d = GRANT;
          g_d     = win;
          ptr_d   = (ARB_MODE == 0) ? win : ptr_q;
        end
      end
      GRANT:   state_d = !m_cyc_i[g_q] ? IDLE : fire ? ABORT : GRANT;
      ABORT:   state_d = !m_cyc_i[g_q] ? IDLE : ABORT;
      HOLD:    state_d = !bus_hold ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(MASTERS - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  assign grant_o      = own ? (MASTERS'(1) << g_q) : '0;
  assign bus_hold_ack = (state_q == HOLD);
  assign timeout_o    = tmo_q;
  assign s_adr_o      = own ? m_adr_i[g_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o      = own ? m_dat_i[g_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign s_sel_o      = own ? m_sel_i[g_q*SEL_WIDTH +: SEL_WIDTH] : '0;
  assign s_we_o       = own && m_we_i[g_q];
  assign s_cti_o      = own ? m_cti_i[g_q*3 +: 3] : 3'b000;
  assign s_bte_o      = own ? m_bte_i[g_q*2 +: 2] : 2'b00;
  assign s_cyc_o      = (state_q == GRANT) && m_cyc_i[g_q];
  assign s_stb_o      = (state_q == GRANT) && m_stb_i[g_q];
  assign m_dat_o      = {MASTERS{s_dat_i}};
  assign m_ack_o      = ((state_q == GRANT) && s_ack_i) ? grant_o : '0;
  assign m_rty_o      = ((state_q == GRANT) && s_rty_i) ? grant_o : '0;
  assign m_err_o      = (((state_q == GRANT) && s_err_i) || ((state_q == ABORT) && m_stb_i[g_q])) ? grant_o : '0;
endmodule
